// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter that shares one byte-level UART TX serializer among NUM_REQ sources.
// Optional macro ARB_TIMEOUT_EN adds a per-byte stall limit that force-releases a stalled owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 234,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     scan_sum;
  logic               win_found;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               timeout_nxt;
  logic               xfer;
  logic               owner_last;
  logic               stall_hit;

  // Round-robin scan: first valid source at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
      end else begin
        scan_sum = scan_sum;
      end
      if (!win_found && req_valid[scan_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        winner    = scan_sum[IDX_W-1:0];
      end else begin
        win_found = win_found;
      end
    end
  end

  // Byte path: the owner is wired straight through to the serializer while streaming.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    req_ready = '0;
    if (state == STREAM) begin
      tx_valid         = req_valid[owner];
      tx_data          = req_data[{owner, 3'b000} +: 8];
      req_ready[owner] = tx_ready;
    end else begin
      tx_valid = 1'b0;
    end
  end

  assign xfer       = tx_valid && tx_ready;
  assign owner_last = req_last[owner];

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  assign stall_hit = (state == STREAM) && !xfer &&
                     (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts idle STREAM cycles, cleared by any transfer or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == STREAM) && !xfer && !stall_hit) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next-state logic for the IDLE / STREAM / GAP controller.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    gap_cnt_nxt = gap_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = STREAM;
          grant_nxt = NUM_REQ'(1) << winner;
          owner_nxt = winner;
          ptr_nxt   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if ((xfer && owner_last) || stall_hit) begin
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
          timeout_nxt = stall_hit;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          state_nxt = STREAM;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      owner   <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      gap_cnt <= gap_cnt_nxt;
      busy    <= (state_nxt != IDLE);
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message-level reference model checked every cycle,
// plus literal expectations on byte order, grant order, gap length and reset behaviour.
module tb_uart_tx_arbiter;
  localparam int N    = 2;
  localparam int GAP  = 234;
  localparam int TOUT = 100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_valid, tx_ready, busy, timeout;
  logic [7:0]     tx_data;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant(grant), .busy(busy), .timeout(timeout));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Source queues: bit 9 = pause 400 cycles before presenting, bit 8 = last, [7:0] = data.
  logic [9:0] src_q[N][$];
  int         dly_left[N];
  int         tx_mode = 0;

  int         log_src[$];
  logic [7:0] log_byte[$];
  int         msg_src[$];
  int         last_acc_cyc, busy_fall_cyc, tout_count;
  bit         prev_busy;

  int m_owner, m_gap, m_prio, m_stall;
  bit m_tout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_prio = 0; m_stall = 0; m_tout = 1'b0;
  endtask

  task automatic model_release();
    m_owner = -1;
    m_gap   = GAP;
  endtask

  // Reference model: whoever owns the line passes bytes straight through; one message per grant.
  task automatic model_step();
    logic [N-1:0] e_grant, e_rdy;
    logic         e_valid, e_busy;
    logic [7:0]   e_data;
    e_grant = '0; e_rdy = '0; e_valid = 1'b0; e_data = 8'd0;
    e_busy  = (m_owner >= 0) || (m_gap > 0);
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_valid          = req_valid[m_owner];
      e_data           = req_data[8*m_owner +: 8];
      e_rdy[m_owner]   = tx_ready;
    end
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("tx_valid", tx_valid, e_valid);
    chk("tx_data", tx_data, e_data);
    chk("req_ready", req_ready, e_rdy);
    chk("timeout", timeout, m_tout);
    if (timeout) tout_count++;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (req_valid[m_owner] && tx_ready) begin
        log_src.push_back(m_owner);
        log_byte.push_back(req_data[8*m_owner +: 8]);
        m_stall = 0;
        if (req_last[m_owner]) begin
          msg_src.push_back(m_owner);
          last_acc_cyc = cyc;
          model_release();
        end
      end else begin
        m_stall++;
`ifdef ARB_TIMEOUT_EN
        if (m_stall == TOUT) begin
          model_release();
          m_tout = 1'b1;
        end
`endif
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_prio + k) % N;
        if (req_valid[s]) begin
          m_owner = s;
          m_prio  = (s + 1) % N;
          m_stall = 0;
          break;
        end
      end
    end
  endtask

  // Compare process.
  initial begin
    model_reset();
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
        prev_busy = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Source and serializer-ready driver.
  initial begin
    int         ph;
    bit         acc[N];
    logic [9:0] tmp;
    ph = 0;
    tx_ready = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) dly_left[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && src_q[i][0][9]) begin
          tmp = src_q[i].pop_front();
          tmp[9] = 1'b0;
          src_q[i].push_front(tmp);
          dly_left[i] = 400;
        end
        if (src_q[i].size() > 0 && dly_left[i] == 0) begin
          req_valid[i]        = 1'b1;
          req_last[i]         = src_q[i][0][8];
          req_data[8*i +: 8]  = src_q[i][0][7:0];
        end else begin
          req_valid[i]        = 1'b0;
          req_last[i]         = 1'b0;
          req_data[8*i +: 8]  = 8'd0;
          if (dly_left[i] > 0) dly_left[i]--;
        end
      end
      ph = (ph + 1) % 234;
      tx_ready = (tx_mode == 0) ? 1'b1 : (ph == 0);
    end
  end

  task automatic push_str(input int s, input string m);
    for (int k = 0; k < m.len(); k++)
      src_q[s].push_back({1'b0, (k == m.len() - 1), m[k]});
  endtask

  task automatic clear_logs();
    log_src.delete(); log_byte.delete(); msg_src.delete(); tout_count = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_budget"}, (n < budget), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bytes(input string name, input string m);
    chk({name, "_count"}, log_byte.size(), m.len());
    for (int k = 0; k < m.len() && k < log_byte.size(); k++)
      chk({name, "_byte"}, log_byte[k], m[k]);
  endtask

  initial begin
    logic [7:0] hello_exp[6];
    int         n;
    hello_exp = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    do_reset();

    // "hello " from source 0, then gap length.
    clear_logs();
    push_str(0, "hello ");
    wait_done(2000, "hello");
    chk("hello_count", log_byte.size(), 6);
    for (int k = 0; k < 6 && k < log_byte.size(); k++) begin
      chk("hello_byte", log_byte[k], hello_exp[k]);
      chk("hello_src", log_src[k], 0);
    end
    chk("busy_fall_after_last", busy_fall_cyc - last_acc_cyc, 235);

    // Simultaneous requests from reset, two messages each: 0,1,0,1 without interleaving.
    do_reset();
    clear_logs();
    push_str(0, "AB"); push_str(0, "EF");
    push_str(1, "cd"); push_str(1, "gh");
    wait_done(3000, "rr");
    chk_bytes("rr", "ABcdEFgh");
    chk("rr_msgs", msg_src.size(), 4);
    for (int k = 0; k < 4 && k < msg_src.size(); k++) chk("rr_order", msg_src[k], k % 2);

    // Serializer stall: ready one cycle in 234 during a 12-byte message.
    clear_logs();
    tx_mode = 1;
    push_str(0, "0123456789:;");
    push_str(1, "zz");
    wait_done(8000, "stall");
    tx_mode = 0;
    chk_bytes("stall", "0123456789:;zz");
    n = 0;
    for (int k = 0; k < log_src.size(); k++) if (log_src[k] == 0) n++;
    chk("stall_src0_xfers", n, 12);

    // Reset mid-message after the third byte.
    clear_logs();
    push_str(0, "abcdef");
    push_str(1, "XY");
    n = 0;
    while (log_byte.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_byte3", (n < 200), 1'b1);
    @(posedge clk);
    #2;
    chk("midrst_pre_tx_valid", tx_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    push_str(1, "pq");
    push_str(0, "rs");
    wait_done(2000, "midrst");
    chk_bytes("midrst_after", "rspq");
    chk("midrst_first_owner", (msg_src.size() > 0) ? msg_src[0] : -1, 0);

    // Owner stalls 400 cycles after its second byte while source 1 waits.
    clear_logs();
    src_q[0].push_back({1'b0, 1'b0, 8'h54});
    src_q[0].push_back({1'b0, 1'b0, 8'h55});
    src_q[0].push_back({1'b1, 1'b0, 8'h56});
    src_q[0].push_back({1'b0, 1'b1, 8'h57});
    push_str(1, "kl");
    wait_done(3000, "stall_owner");
`ifdef ARB_TIMEOUT_EN
    chk_bytes("tout", "TUklVW");
    chk("tout_pulses", tout_count, 1);
`else
    chk_bytes("hold", "TUVWkl");
    chk("hold_pulses", tout_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
